// File: rtl/multdiv_sequencer_pkg.sv
// Shared sequencer definitions: state encodings, counter width and default step counts.
// Imported by the sequencer, its counter, the bus interface and the multdiv datapath.
package multdiv_sequencer_pkg;

   localparam int MULTDIV_CNT_W            = 6;
   localparam int MULTDIV_DEFAULT_MULT_STEPS = 32;
   localparam int MULTDIV_DEFAULT_DIV_STEPS  = 32;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_t;

   // Counter preload for an operation of 'steps' iterations (counts STEPS-1 down to 0).
   function automatic logic [MULTDIV_CNT_W-1:0] step_load(input int steps);
      return MULTDIV_CNT_W'(steps - 1);
   endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Request/iteration bus between the processor multdiv request port, the sequencer and the datapath.
interface multdiv_sequencer_if;
   import multdiv_sequencer_pkg::*;

   logic                     ctrl_MULT;
   logic                     ctrl_DIV;
   logic [MULTDIV_CNT_W-1:0] count;
   logic                     busy;
   logic                     step;
   logic                     first_step;
   logic                     last_step;
   logic                     op_is_div;
   logic                     done;

   modport master (
      output ctrl_MULT, ctrl_DIV,
      input  count, busy, step, first_step, last_step, op_is_div, done
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV,
      output count, busy, step, first_step, last_step, op_is_div, done
   );

endinterface

// File: rtl/multdiv_sequencer_down_counter6.sv
// Toggle cell: flips q on a rising edge when t is high.
// Latency: one cycle from t to q.
// Backpressure: none; t is honoured every cycle.
module T_flip_flop (
   input  logic clock,
   input  logic reset,
   input  logic t,
   output logic q
);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) q <= 1'b0;
      else if (t) q <= ~q;
   end
endmodule

// Loadable 6-bit down-counter built from toggle cells, async clear.
// Latency: load or decrement visible one cycle after the enabling edge.
// Backpressure: none; load has priority over en.
module down_counter6
   import multdiv_sequencer_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load,
   input  logic [MULTDIV_CNT_W-1:0] load_val,
   input  logic                     en,
   output logic [MULTDIV_CNT_W-1:0] count
);
   logic [MULTDIV_CNT_W-1:0] tog;

   for (genvar i = 0; i < MULTDIV_CNT_W; i++) begin : g_bit
      logic borrow;
      if (i == 0) begin : g_lsb
         assign borrow = en;
      end else begin : g_upper
         assign borrow = en & ~|count[i-1:0];
      end
      // Loading toggles exactly the bits that differ from the target value.
      assign tog[i] = load ? (count[i] ^ load_val[i]) : borrow;

      T_flip_flop u_tff (
         .clock (clock),
         .reset (reset),
         .t     (tog[i]),
         .q     (count[i])
      );
   end
endmodule

// File: rtl/multdiv_sequencer.sv
// Multiply/divide iteration sequencer: issues STEPS step cycles per request, then a done pulse.
// Latency: request at edge k -> RUN cycles k..k+STEPS-1, done in cycle k+STEPS.
// Backpressure: none; a new request at any time restarts and discards the current operation.
module multdiv_sequencer
   import multdiv_sequencer_pkg::*;
#(
   parameter int MULT_STEPS = MULTDIV_DEFAULT_MULT_STEPS,
   parameter int DIV_STEPS  = MULTDIV_DEFAULT_DIV_STEPS
) (
   input  logic               clock,
   input  logic               reset,
   multdiv_sequencer_if.slave bus
);
   localparam logic [MULTDIV_CNT_W-1:0] MULT_LOAD = step_load(MULT_STEPS);
   localparam logic [MULTDIV_CNT_W-1:0] DIV_LOAD  = step_load(DIV_STEPS);

   seq_state_t               state, state_nxt;
   logic                     start;
   logic                     cnt_en;
   logic                     first_q;
   logic                     op_div_q;
   logic [MULTDIV_CNT_W-1:0] load_val;
   logic [MULTDIV_CNT_W-1:0] count;

   assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
   assign load_val = bus.ctrl_DIV ? DIV_LOAD : MULT_LOAD;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= SEQ_IDLE;
         first_q  <= 1'b0;
         op_div_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         first_q <= start;
         if (start) op_div_q <= bus.ctrl_DIV;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_en    = 1'b0;
      case (state)
         SEQ_IDLE: state_nxt = SEQ_IDLE;
         SEQ_RUN: begin
            if (count != '0) cnt_en = 1'b1;
            else             state_nxt = SEQ_DONE;
         end
         SEQ_DONE: state_nxt = SEQ_IDLE;
         default:  state_nxt = SEQ_IDLE;
      endcase
      // A request overrides everything, including an operation in flight.
      if (start) begin
         state_nxt = SEQ_RUN;
         cnt_en    = 1'b0;
      end
   end

   down_counter6 u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (start),
      .load_val (load_val),
      .en       (cnt_en),
      .count    (count)
   );

   assign bus.count      = count;
   assign bus.busy       = (state == SEQ_RUN);
   assign bus.step       = (state == SEQ_RUN);
   assign bus.first_step = first_q;
   assign bus.last_step  = (state == SEQ_RUN) && (count == '0);
   assign bus.op_is_div  = op_div_q;
   assign bus.done       = (state == SEQ_DONE);

endmodule
